cpu_step_ctrl: RTL and testbench

Parametrised clock-step controller for the pipelined CPU debug board. It takes the raw step and reset buttons and produces single-cycle pipeline enable and reset pulses, a wrapping cycle counter, and a display-refresh strobe. Beyond manual stepping, it adds a free-run mode with a programmable step rate and a PC breakpoint that halts free-run. It sits between the board buttons/switches and the if/id/ex/mem/wb stage clock-enable inputs and the LCD string builder.

---
 rtl/cpu_step_ctrl.sv | 165 ++++++++++++++++
 tb/tb_cpu_step_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_ctrl.sv
// Clock-step controller for the pipelined CPU debug board: debounced step/reset
// buttons, manual and free-run stepping with a PC breakpoint, cycle counter.
module cpu_step_ctrl #(
    parameter int unsigned DB_CYCLES = 50000,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned RUN_DIV   = 25000000,
    parameter int unsigned PC_W      = 32
) (
    input  logic             CCLK,
    input  logic             RSTN,
    input  logic             btn_step,
    input  logic             btn_rst,
    input  logic             run_mode,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    output logic             cpu_step,
    output logic             cpu_rst,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic             halted,
    output logic             disp_refresh
);

    localparam int unsigned DB_W  = $clog2(DB_CYCLES);
    localparam int unsigned DIV_W = $clog2(RUN_DIV);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {ST_MANUAL, ST_RUN, ST_HALT} state_t;

    // Bit 0 carries the step button, bit 1 the reset button.
    logic [1:0]      raw;
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      db_lvl_q, db_lvl_d;
    logic [1:0]      press_q, press_d;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic             step_q, step_d;
    logic             rst_q, rst_d;
    logic             halted_q, halted_d;
    logic             disp_q, disp_d;

    assign raw = {btn_rst, btn_step};

    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            db_lvl_d[i] = db_lvl_q[i];
            db_cnt_d[i] = '0;
            press_d[i]  = 1'b0;
            if (sync2_q[i] != db_lvl_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_lvl_d[i] = sync2_q[i];
                    press_d[i]  = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        halted_d  = halted_q;
        step_d    = 1'b0;
        rst_d     = 1'b0;
        disp_d    = step_q | rst_q;
        cyc_cnt_d = cyc_cnt_q;

        if (press_q[1]) begin
            // Reset press overrides any step or tick in the same cycle.
            rst_d     = 1'b1;
            cyc_cnt_d = '0;
            div_d     = '0;
            halted_d  = 1'b0;
            state_d   = run_mode ? ST_RUN : ST_MANUAL;
        end else begin
            unique case (state_q)
                ST_MANUAL: begin
                    step_d = press_q[0];
                    if (run_mode) begin
                        state_d = ST_RUN;
                        div_d   = '0;
                    end
                end
                ST_RUN: begin
                    if (!run_mode) begin
                        state_d = ST_MANUAL;
                    end else if (div_q == DIV_LAST) begin
                        div_d = '0;
                        if (bp_en && (pc == bp_addr)) begin
                            state_d  = ST_HALT;
                            halted_d = 1'b1;
                        end else begin
                            step_d = 1'b1;
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                ST_HALT: begin
                    if (press_q[0]) begin
                        step_d   = 1'b1;
                        halted_d = 1'b0;
                        div_d    = '0;
                        state_d  = run_mode ? ST_RUN : ST_MANUAL;
                    end else if (!run_mode) begin
                        state_d  = ST_MANUAL;
                        halted_d = 1'b0;
                    end
                end
                default: state_d = ST_MANUAL;
            endcase
        end

        if (step_d) begin
            cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CCLK or negedge RSTN) begin
        if (!RSTN) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_lvl_q  <= '0;
            press_q   <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
            end
            state_q   <= ST_MANUAL;
            div_q     <= '0;
            cyc_cnt_q <= '0;
            step_q    <= 1'b0;
            rst_q     <= 1'b0;
            halted_q  <= 1'b0;
            disp_q    <= 1'b0;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            db_lvl_q  <= db_lvl_d;
            press_q   <= press_d;
            for (int unsigned i = 0; i < 2; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            state_q   <= state_d;
            div_q     <= div_d;
            cyc_cnt_q <= cyc_cnt_d;
            step_q    <= step_d;
            rst_q     <= rst_d;
            halted_q  <= halted_d;
            disp_q    <= disp_d;
        end
    end

    assign cpu_step     = step_q;
    assign cpu_rst      = rst_q;
    assign cyc_cnt      = cyc_cnt_q;
    assign halted       = halted_q;
    assign disp_refresh = disp_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Self-checking bench for cpu_step_ctrl: cycle-level reference model compared
// every cycle, plus a vector table and directed multi-cycle sequences.
module tb_cpu_step_ctrl;

    localparam int DB = 4;
    localparam int CW = 4;
    localparam int RD = 3;
    localparam int N  = DB + 2;
    localparam int MANUAL = 0;
    localparam int RUN    = 1;
    localparam int HALT   = 2;

    logic          CCLK = 1'b0;
    logic          RSTN;
    logic          btn_step, btn_rst, run_mode, bp_en;
    logic [31:0]   bp_addr, pc;
    logic          cpu_step, cpu_rst, halted, disp_refresh;
    logic [CW-1:0] cyc_cnt;

    int checks   = 0;
    int failures = 0;

    cpu_step_ctrl #(.DB_CYCLES(DB), .CNT_W(CW), .RUN_DIV(RD), .PC_W(32)) dut (
        .CCLK(CCLK), .RSTN(RSTN), .btn_step(btn_step), .btn_rst(btn_rst),
        .run_mode(run_mode), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
        .cpu_step(cpu_step), .cpu_rst(cpu_rst), .cyc_cnt(cyc_cnt),
        .halted(halted), .disp_refresh(disp_refresh)
    );

    always #5 CCLK = ~CCLK;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a button's level flips once the last DB synchronised
    // samples (raw samples delayed two clocks) all differ from it.
    bit hist [2][N];
    bit m_lvl [2];
    bit m_prs [2];
    int m_mode = MANUAL;
    int m_phase = 0;
    int m_cnt = 0;
    bit m_step = 0, m_rst = 0, m_halt = 0, m_disp = 0;

    always @(posedge CCLK or negedge RSTN) begin : model
        bit t_hist [2][N];
        bit t_lvl [2];
        bit t_prs [2];
        bit r [2];
        bit all_diff, t_step, t_rst, t_halt, tick;
        int t_mode, t_phase, t_cnt;
        if (!RSTN) begin
            hist    <= '{default: '{default: 1'b0}};
            m_lvl   <= '{default: 1'b0};
            m_prs   <= '{default: 1'b0};
            m_mode  <= MANUAL;
            m_phase <= 0;
            m_cnt   <= 0;
            m_step  <= 1'b0;
            m_rst   <= 1'b0;
            m_halt  <= 1'b0;
            m_disp  <= 1'b0;
        end else begin
            r[0] = btn_step;
            r[1] = btn_rst;
            t_hist = hist;
            t_lvl  = m_lvl;
            for (int b = 0; b < 2; b++) begin
                all_diff = 1'b1;
                for (int j = 1; j <= DB; j++)
                    if (hist[b][j] == m_lvl[b]) all_diff = 1'b0;
                t_prs[b] = 1'b0;
                if (all_diff) begin
                    t_lvl[b] = ~m_lvl[b];
                    t_prs[b] = t_lvl[b];
                end
                for (int j = 0; j < N - 1; j++) t_hist[b][j] = hist[b][j+1];
                t_hist[b][N-1] = r[b];
            end

            t_step = 1'b0; t_rst = 1'b0; t_halt = m_halt;
            t_mode = m_mode; t_phase = m_phase; t_cnt = m_cnt;
            if (m_prs[1]) begin
                t_rst = 1'b1; t_cnt = 0; t_phase = 0; t_halt = 1'b0;
                t_mode = run_mode ? RUN : MANUAL;
            end else if (m_mode == MANUAL) begin
                t_step = m_prs[0];
                if (run_mode) begin t_mode = RUN; t_phase = 0; end
            end else if (m_mode == RUN) begin
                if (!run_mode) t_mode = MANUAL;
                else begin
                    tick = ((m_phase + 1) % RD) == 0;
                    t_phase = m_phase + 1;
                    if (tick && bp_en && pc == bp_addr) begin
                        t_mode = HALT; t_halt = 1'b1;
                    end else if (tick) t_step = 1'b1;
                end
            end else begin
                if (m_prs[0]) begin
                    t_step = 1'b1; t_halt = 1'b0; t_phase = 0;
                    t_mode = run_mode ? RUN : MANUAL;
                end else if (!run_mode) begin
                    t_mode = MANUAL; t_halt = 1'b0;
                end
            end
            if (t_step) t_cnt = (m_cnt + 1) % (2 ** CW);

            hist    <= t_hist;
            m_lvl   <= t_lvl;
            m_prs   <= t_prs;
            m_mode  <= t_mode;
            m_phase <= t_phase;
            m_cnt   <= t_cnt;
            m_step  <= t_step;
            m_rst   <= t_rst;
            m_halt  <= t_halt;
            m_disp  <= m_step | m_rst;
        end
    end

    always @(negedge CCLK) begin
        if (RSTN) begin
            chk("model_cpu_step", cpu_step, m_step);
            chk("model_cpu_rst", cpu_rst, m_rst);
            chk("model_cyc_cnt", cyc_cnt, m_cnt);
            chk("model_halted", halted, m_halt);
            chk("model_disp", disp_refresh, m_disp);
        end else begin
            chk("rst_cpu_step", cpu_step, 0);
            chk("rst_cpu_rst", cpu_rst, 0);
            chk("rst_cyc_cnt", cyc_cnt, 0);
            chk("rst_halted", halted, 0);
            chk("rst_disp", disp_refresh, 0);
        end
    end

    task automatic run_cycles(input int n, output int steps);
        steps = 0;
        repeat (n) begin
            @(negedge CCLK);
            if (cpu_step) steps++;
        end
    endtask

    // Cycles until cpu_step is seen, or -1 once the budget runs out.
    task automatic wait_step(input int bound, output int n);
        n = -1;
        for (int c = 1; c <= bound; c++) begin
            @(negedge CCLK);
            if (cpu_step) begin n = c; break; end
        end
    endtask

    task automatic press_step();
        int s;
        btn_step = 1'b1;
        run_cycles(6, s);
        btn_step = 1'b0;
        run_cycles(8, s);
    endtask

    typedef struct {
        int hold;
        int exp_steps;
        int exp_cnt;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int s, t, n;
        vecs[0] = '{1, 0, 0};
        vecs[1] = '{3, 0, 0};
        vecs[2] = '{4, 1, 1};
        vecs[3] = '{10, 1, 2};
        vecs[4] = '{2, 0, 2};
        vecs[5] = '{6, 1, 3};

        RSTN = 1'b0; btn_step = 1'b0; btn_rst = 1'b0; run_mode = 1'b0;
        bp_en = 1'b0; bp_addr = '0; pc = '0;
        repeat (3) @(negedge CCLK);
        RSTN = 1'b1;

        // Glitch filtering: a hold shorter than DB never reaches the pipeline.
        for (int i = 0; i < 6; i++) begin
            btn_step = 1'b1;
            run_cycles(vecs[i].hold, s);
            btn_step = 1'b0;
            run_cycles(20, t);
            chk($sformatf("vec%0d_steps", i), s + t, vecs[i].exp_steps);
            chk($sformatf("vec%0d_cnt", i), cyc_cnt, vecs[i].exp_cnt);
        end

        // Counter wrap at 2^CW.
        @(negedge CCLK); #2 RSTN = 1'b0;
        @(negedge CCLK); #2 RSTN = 1'b1;
        for (int i = 0; i < 17; i++) begin
            press_step();
            chk($sformatf("wrap_cnt%0d", i), cyc_cnt, (i + 1) % 16);
        end

        // Free-run cadence and stopping.
        run_mode = 1'b1;
        wait_step(10, n);
        chk("run_first", n, 4);
        for (int i = 0; i < 4; i++) begin
            wait_step(10, n);
            chk("run_period", n, RD);
        end
        run_mode = 1'b0;
        run_cycles(10, s);
        chk("run_stop", s, 0);

        // Breakpoint halt and resume by step press.
        bp_addr = 32'h0000_000C; pc = 32'h0000_000C; bp_en = 1'b1; run_mode = 1'b1;
        s = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CCLK);
            if (cpu_step) s++;
            if (halted) break;
        end
        chk("bp_halted", halted, 1);
        chk("bp_no_step", s, 0);
        pc = 32'h0000_0010;
        run_cycles(6, s);
        chk("bp_stay_steps", s, 0);
        chk("bp_stay_halted", halted, 1);
        btn_step = 1'b1;
        wait_step(15, n);
        chk("bp_resume_latency", n, DB + 3);
        chk("bp_resume_halted", halted, 0);
        wait_step(10, n);
        chk("bp_resume_period", n, RD);
        btn_step = 1'b0; run_mode = 1'b0; bp_en = 1'b0;
        run_cycles(12, s);

        // Reset and step debounced in the same cycle.
        btn_step = 1'b1; btn_rst = 1'b1;
        s = 0; n = -1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge CCLK);
            if (cpu_step) s++;
            if (cpu_rst) begin n = c; break; end
        end
        chk("both_rst_latency", n, DB + 3);
        chk("both_no_step", s, 0);
        chk("both_step_low", cpu_step, 0);
        chk("both_cnt_zero", cyc_cnt, 0);
        @(negedge CCLK);
        chk("both_disp", disp_refresh, 1);
        chk("both_rst_single", cpu_rst, 0);
        btn_step = 1'b0; btn_rst = 1'b0;
        run_cycles(12, s);

        // RSTN while the step button is held.
        btn_step = 1'b1;
        run_cycles(10, s);
        chk("hold_pre_cnt", cyc_cnt, 1);
        @(negedge CCLK); #2 RSTN = 1'b0;
        #1 chk("hold_async_cnt", cyc_cnt, 0);
        repeat (2) @(negedge CCLK);
        #2 RSTN = 1'b1;
        wait_step(20, n);
        chk("hold_release_latency", n, DB + 3);
        btn_step = 1'b0;
        run_cycles(12, s);

        // Randomised traffic against the reference model.
        for (int seg = 0; seg < 250; seg++) begin
            run_mode = ($urandom_range(0, 3) != 0);
            bp_en    = 1'($urandom_range(0, 1));
            bp_addr  = 32'h8;
            pc       = 32'($urandom_range(1, 3)) * 32'h4;
            btn_step = ($urandom_range(0, 2) == 0);
            btn_rst  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 39) == 0) begin
                #2 RSTN = 1'b0;
                @(negedge CCLK);
                #2 RSTN = 1'b1;
            end
            repeat ($urandom_range(1, 9)) @(negedge CCLK);
        end
        btn_step = 1'b0; btn_rst = 1'b0;
        repeat (4) @(negedge CCLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
